// File: rtl/sliding_window_unit.sv
// rtl/sliding_window_unit.sv - K x K sliding window generator over a raster-order pixel stream
`timescale 1ns/1ps
module sliding_window_unit #(
    parameter int DATA_WIDTH        = 32,
    parameter int MAX_KERNEL_SIZE   = 5,
    parameter int KERNEL_SIZE_WIDTH = 3,
    parameter int MAX_IMG_SIZE      = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [KERNEL_SIZE_WIDTH-1:0] fu_kernel_size_in,
    input  logic [11:0]                  fu_img_size_in,
    input  logic [DATA_WIDTH-1:0]        fu_pixel_in,
    input  logic                         fu_pixel_valid_in,
    output logic [DATA_WIDTH-1:0]        fu_window_out [0:MAX_KERNEL_SIZE*MAX_KERNEL_SIZE-1],
    output logic                         fu_window_valid_out,
    output logic                         frame_done_out,
    output logic                         cfg_err_out,
    output logic                         busy_out
);
    localparam int MK = MAX_KERNEL_SIZE;
    localparam int NW = MK * MK;
    localparam int LB = (MK > 1) ? MK - 1 : 1;
    localparam int CW = (MAX_IMG_SIZE > 1) ? $clog2(MAX_IMG_SIZE) : 1;
    localparam int RW = (MK > 1) ? $clog2(MK) : 1;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KERNEL_SIZE_WIDTH:0] MAX_K = MAX_KERNEL_SIZE[KERNEL_SIZE_WIDTH:0];
    localparam logic [11:0]                MAX_N = MAX_IMG_SIZE[11:0];

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state, state_n;
    logic [KERNEL_SIZE_WIDTH-1:0]  k_q, cur_k;
    logic [11:0]                   n_q, cur_n, in_n_eff;
    logic                          ok_q, cur_ok, in_ok;
    logic [11:0]                   row, col, row_n, col_n, km1, nm1;
    logic                          emit, last;
    int                            kk;

    // Window kept right-aligned in an MK x MK array: row MK-1 is the current
    // image row, column MK-1 the current column; smaller K uses the bottom-right corner.
    logic [DATA_WIDTH-1:0] win   [0:MK-1][0:MK-1];
    logic [DATA_WIDTH-1:0] win_n [0:MK-1][0:MK-1];
    logic [DATA_WIDTH-1:0] pack  [0:NW-1];
    // linebuf[j][c] holds the pixel from j+1 rows above at column c.
    logic [DATA_WIDTH-1:0] linebuf [0:LB-1][0:MAX_IMG_SIZE-1];

    assign busy_out = (state == RUN);

    // Validate the configuration on the stream and derive the pixel-count size
    always_comb begin
        in_ok = (fu_kernel_size_in != '0) && ({1'b0, fu_kernel_size_in} <= MAX_K) &&
                (fu_img_size_in != '0) && (fu_img_size_in <= MAX_N);
        if (fu_img_size_in == '0)
            in_n_eff = 12'd1;
        else if (fu_img_size_in > MAX_N)
            in_n_eff = MAX_N;
        else
            in_n_eff = fu_img_size_in;
    end

    // Next state, counter advance, window shift and compact packing of the emitted window
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        cur_k   = (state == IDLE) ? fu_kernel_size_in : k_q;
        cur_n   = (state == IDLE) ? in_n_eff : n_q;
        cur_ok  = (state == IDLE) ? in_ok : ok_q;
        kk      = int'(cur_k);
        km1     = {{(12-KERNEL_SIZE_WIDTH){1'b0}}, cur_k} - 12'd1;
        nm1     = cur_n - 12'd1;
        last    = fu_pixel_valid_in && (row == nm1) && (col == nm1);
        emit    = fu_pixel_valid_in && cur_ok && (row >= km1) && (col >= km1);
        win_n   = win;
        pack    = '{default: '0};
        if (fu_pixel_valid_in) begin
            for (int r = 0; r < MK; r++)
                for (int c = 0; c < MK - 1; c++)
                    win_n[r][c] = win[r][c+1];
            for (int r = 0; r < MK - 1; r++)
                win_n[r][MK-1] = linebuf[MK-2-r][col[CW-1:0]];
            win_n[MK-1][MK-1] = fu_pixel_in;
            if (last) begin
                state_n = IDLE;
                row_n   = '0;
                col_n   = '0;
            end else begin
                state_n = RUN;
                if (col == nm1) begin
                    col_n = '0;
                    row_n = row + 12'd1;
                end else begin
                    col_n = col + 12'd1;
                end
            end
        end
        if (cur_ok) begin
            for (int r = 0; r < MK; r++)
                for (int c = 0; c < MK; c++)
                    if (r < kk && c < kk)
                        pack[IW'(r*kk + c)] = win_n[RW'(MK-kk+r)][RW'(MK-kk+c)];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Frame configuration, position counters, window and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q                 <= '0;
            n_q                 <= '0;
            ok_q                <= 1'b0;
            row                 <= '0;
            col                 <= '0;
            fu_window_valid_out <= 1'b0;
            frame_done_out      <= 1'b0;
            cfg_err_out         <= 1'b0;
            for (int i = 0; i < NW; i++)
                fu_window_out[i] <= '0;
            for (int r = 0; r < MK; r++)
                for (int c = 0; c < MK; c++)
                    win[r][c] <= '0;
        end else begin
            row                 <= row_n;
            col                 <= col_n;
            win                 <= win_n;
            fu_window_valid_out <= emit;
            frame_done_out      <= last;
            if (emit)
                fu_window_out <= pack;
            if (state == IDLE && fu_pixel_valid_in) begin
                k_q  <= fu_kernel_size_in;
                n_q  <= in_n_eff;
                ok_q <= in_ok;
                if (!in_ok)
                    cfg_err_out <= 1'b1;
            end
        end
    end

    // Line buffers push each accepted pixel one row deeper at the current column
    always_ff @(posedge clk) begin
        if (fu_pixel_valid_in) begin
            linebuf[0][col[CW-1:0]] <= fu_pixel_in;
            for (int j = 1; j < LB; j++)
                linebuf[j][col[CW-1:0]] <= linebuf[j-1][col[CW-1:0]];
        end
    end
endmodule

// File: tb/tb_sliding_window_unit.sv
// tb/tb_sliding_window_unit.sv - directed table-driven bench for sliding_window_unit
`timescale 1ns/1ps
module tb_sliding_window_unit;
    localparam int MK = 5;
    localparam int NW = MK * MK;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  fu_kernel_size_in = '0;
    logic [11:0] fu_img_size_in = '0;
    logic [31:0] fu_pixel_in = '0;
    logic        fu_pixel_valid_in = 1'b0;
    logic [31:0] fu_window_out [0:NW-1];
    logic        fu_window_valid_out, frame_done_out, cfg_err_out, busy_out;

    sliding_window_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .fu_kernel_size_in   (fu_kernel_size_in),
        .fu_img_size_in      (fu_img_size_in),
        .fu_pixel_in         (fu_pixel_in),
        .fu_pixel_valid_in   (fu_pixel_valid_in),
        .fu_window_out       (fu_window_out),
        .fu_window_valid_out (fu_window_valid_out),
        .frame_done_out      (frame_done_out),
        .cfg_err_out         (cfg_err_out),
        .busy_out            (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [31:0] e [NW]; } win_rec_t;
    typedef struct { int k; int n; int base; bit gaps; bit exp_err; } vec_t;

    win_rec_t win_q [$];
    int       done_q [$];
    int       acc_q [$];
    int       cyc = 0;
    int       err_cyc = -1;
    int       total = 0;
    int       bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endfunction

    always @(negedge clk) begin : mon
        win_rec_t w;
        if (fu_window_valid_out === 1'b1) begin
            w.cyc = cyc;
            for (int i = 0; i < NW; i++) w.e[i] = fu_window_out[i];
            win_q.push_back(w);
        end
        if (frame_done_out === 1'b1) begin
            done_q.push_back(cyc);
            chk("busy_low_at_done", busy_out, 0);
        end
        if (cfg_err_out === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_zero(input string name);
        logic any;
        any = fu_window_valid_out | frame_done_out | cfg_err_out | busy_out;
        for (int i = 0; i < NW; i++) any = any | (|fu_window_out[i]);
        chk(name, any, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fu_pixel_valid_in = 1'b0;
        @(negedge clk);
        chk_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        win_q.delete();
        done_q.delete();
        acc_q.delete();
        err_cyc = -1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fu_pixel_valid_in = 1'b0;
        end
    endtask

    task automatic drive_frame(input int k, input int n, input int base, input int npix, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            if (i == 1) chk("busy_after_first_pixel", busy_out, 1);
            fu_pixel_in = base + i;
            fu_pixel_valid_in = 1'b1;
            if (i == 0) begin
                fu_kernel_size_in = 3'(k);
                fu_img_size_in = 12'(n);
            end else begin
                fu_kernel_size_in = 3'($urandom);
                fu_img_size_in = 12'($urandom);
            end
            acc_q.push_back(cyc);
            if (gaps) begin
                @(negedge clk);
                fu_pixel_valid_in = 1'b0;
                fu_pixel_in = 32'hBAD0_0000 + i;
            end
        end
    endtask

    task automatic chk_win(input string name, input int idx, input int exp_v [9]);
        int bad_i, want, bad_want;
        total++;
        if (idx >= win_q.size()) begin
            bad++;
            $display("FAIL %s: window %0d absent, got %0d windows", name, idx, win_q.size());
            return;
        end
        bad_i = -1;
        bad_want = 0;
        for (int i = 0; i < NW; i++) begin
            want = (i < 9) ? exp_v[i] : 0;
            if (bad_i < 0 && win_q[idx].e[i] !== 32'(want)) begin
                bad_i = i;
                bad_want = want;
            end
        end
        if (bad_i >= 0) begin
            bad++;
            $display("FAIL %s: entry %0d got %0d want %0d", name, bad_i, win_q[idx].e[bad_i], bad_want);
        end
    endtask

    task automatic check_frame(input int k, input int n, input int base);
        int neff, nexp, done, cnt, bad_i, want, bad_want;
        bit ok;
        int acc [$];
        win_rec_t w;
        neff = (n == 0) ? 1 : ((n > 64) ? 64 : n);
        ok = (k >= 1) && (k <= MK) && (n >= 1) && (n <= 64);
        nexp = (ok && k <= neff) ? (neff - k + 1) * (neff - k + 1) : 0;
        for (int i = 0; i < neff * neff; i++)
            if (acc_q.size() > 0) acc.push_back(acc_q.pop_front());
        chk("frame_done_seen", done_q.size() > 0, 1);
        if (done_q.size() == 0 || acc.size() != neff * neff) return;
        done = done_q.pop_front();
        chk("frame_done_cyc", done, acc[neff*neff-1] + 1);
        cnt = 0;
        for (int i = 0; i < win_q.size(); i++)
            if (win_q[i].cyc <= done) cnt++;
        chk("window_count", cnt, nexp);
        if (nexp > 0) begin
            for (int row = k - 1; row < neff; row++) begin
                for (int col = k - 1; col < neff; col++) begin
                    if (win_q.size() > 0) begin
                        w = win_q.pop_front();
                        chk("window_cyc", w.cyc, acc[row*neff+col] + 1);
                        bad_i = -1;
                        bad_want = 0;
                        for (int i = 0; i < NW; i++) begin
                            want = (i < k*k) ? base + (row-k+1+i/k)*neff + (col-k+1+i%k) : 0;
                            if (bad_i < 0 && w.e[i] !== 32'(want)) begin
                                bad_i = i;
                                bad_want = want;
                            end
                        end
                        total++;
                        if (bad_i >= 0) begin
                            bad++;
                            $display("FAIL window_data row%0d col%0d idx%0d: got %0d want %0d",
                                     row, col, bad_i, w.e[bad_i], bad_want);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        vec_t vecs [6];
        int   w_first [9], w_fourth [9], b0 [9], b1 [9], b2 [9], b3 [9];
        int   neff;

        vecs[0] = '{3, 4,   100, 1'b0, 1'b0};
        vecs[1] = '{3, 4,   100, 1'b1, 1'b0};
        vecs[2] = '{1, 4,   200, 1'b0, 1'b0};
        vecs[3] = '{5, 4,   300, 1'b0, 1'b0};
        vecs[4] = '{6, 4,   400, 1'b0, 1'b1};
        vecs[5] = '{3, 100, 500, 1'b0, 1'b1};
        w_first  = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        w_fourth = '{105, 106, 107, 109, 110, 111, 113, 114, 115};
        b0 = '{0, 1, 3, 4, 0, 0, 0, 0, 0};
        b1 = '{1, 2, 4, 5, 0, 0, 0, 0, 0};
        b2 = '{3, 4, 6, 7, 0, 0, 0, 0, 0};
        b3 = '{4, 5, 7, 8, 0, 0, 0, 0, 0};

        for (int v = 0; v < 6; v++) begin
            neff = (vecs[v].n == 0) ? 1 : ((vecs[v].n > 64) ? 64 : vecs[v].n);
            do_reset();
            drive_frame(vecs[v].k, vecs[v].n, vecs[v].base, neff * neff, vecs[v].gaps);
            idle(4);
            if (v == 0) begin
                chk_win("first_window", 0, w_first);
                chk_win("fourth_window", 3, w_fourth);
            end
            chk("cfg_err_level", cfg_err_out, vecs[v].exp_err);
            chk("cfg_err_onset", err_cyc, vecs[v].exp_err ? acc_q[0] + 1 : -1);
            check_frame(vecs[v].k, vecs[v].n, vecs[v].base);
            chk("no_extra_windows", win_q.size(), 0);
        end

        // reset in the middle of a frame, then a fresh frame
        do_reset();
        drive_frame(3, 4, 100, 7, 1'b0);
        @(negedge clk);
        chk("busy_mid_frame", busy_out, 1);
        rst = 1'b1;
        fu_pixel_valid_in = 1'b0;
        @(negedge clk);
        chk_zero("midframe_reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        chk("abort_no_done", done_q.size(), 0);
        chk("abort_no_windows", win_q.size(), 0);
        acc_q.delete();
        drive_frame(3, 4, 100, 16, 1'b0);
        idle(4);
        chk_win("after_abort_first_window", 0, w_first);
        check_frame(3, 4, 100);
        chk("after_abort_no_extra", win_q.size(), 0);

        // back-to-back frames with no bubble and a kernel/size change
        do_reset();
        drive_frame(3, 4, 100, 16, 1'b0);
        drive_frame(2, 3, 0, 9, 1'b0);
        idle(4);
        chk_win("b2b_win0", 4, b0);
        chk_win("b2b_win1", 5, b1);
        chk_win("b2b_win2", 6, b2);
        chk_win("b2b_win3", 7, b3);
        check_frame(3, 4, 100);
        check_frame(2, 3, 0);
        chk("b2b_no_extra", win_q.size(), 0);
        chk("b2b_idle_busy", busy_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sliding_window_unit.md
# sliding_window_unit

- Consumes the raster-order pixel stream that `fetch_unit` produces (`swu_pixel_out` / `swu_pixel_valid_out`), together with the kernel size and image size it forwards.
- Builds every fully-inside K×K window of an N×N image, with no padding and stride 1, using K-1 line buffers and a K×K register window.
- Returns each window to `fetch_unit` on its `swu_window_in` / `swu_window_valid_in` inputs, which forward it to the PE array.

## Interface
Parameters:
- DATA_WIDTH, 32, pixel width
- MAX_KERNEL_SIZE, 5, largest supported K
- KERNEL_SIZE_WIDTH, 3, width of kernel-size input
- MAX_IMG_SIZE, 64, largest supported N; sets line-buffer depth

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fu_kernel_size_in  in  KERNEL_SIZE_WIDTH  K
- fu_img_size_in  in  12  N (image is N×N)
- fu_pixel_in  in  DATA_WIDTH  pixel, raster order
- fu_pixel_valid_in  in  1  one pixel accepted per cycle when high; no backpressure
- fu_window_out  out  DATA_WIDTH × MAX_KERNEL_SIZE²  unpacked array [0:MAX_KERNEL_SIZE²-1]
- fu_window_valid_out  out  1  single-cycle strobe per window
- frame_done_out  out  1  single-cycle strobe after the last pixel of a frame
- cfg_err_out  out  1  sticky configuration error
- busy_out  out  1  high while a frame is in progress

## Operation
- States: IDLE, RUN.
- Reset clears the state to IDLE, row/col counters to 0, and every output to 0, including all window entries. Line-buffer contents are don't-care.
- **IDLE:**
  - On the first `fu_pixel_valid_in`, latch K and N, process that pixel as (row 0, col 0), then go to RUN.
  - Set `busy_out` = 1 from the following cycle.
- **Configuration check at latch:**
  - Invalid when K=0, K>MAX_KERNEL_SIZE, N=0, or N>MAX_IMG_SIZE.
  - Invalid config: set `cfg_err_out` (sticky until `rst`). Pixels are still counted against N clamped to MAX_IMG_SIZE, with N=0 treated as 1. No windows are emitted.
- **RUN:** each accepted pixel at (row, col):
  - Shift the window left one column. The new right column is, top to bottom, linebuf[K-2][col] … linebuf[0][col], then the pixel.
  - Chain the line buffers: linebuf[j][col] ← linebuf[j-1][col]; linebuf[0][col] ← pixel.
  - Advance col; when col wraps at N-1, reset col to 0 and increment row.
- **Window emit:** when row ≥ K-1 and col ≥ K-1 and the config is valid, emit a window.
  - Element (r,c), r,c ∈ [0,K), is pixel (row-K+1+r, col-K+1+c).
  - It is placed at index r·K+c (compact packing). Indices ≥ K² are 0.
- Window entries hold their value until the next emit.
- After pixel (N-1, N-1):
  - Pulse `frame_done_out`.
  - Clear counters and return to IDLE.
  - `busy_out` drops together with `frame_done_out`.
- K > N with a valid config: no windows, frame completes normally.
- Gaps in `fu_pixel_valid_in` cause no state change; the window is preserved across gaps.
- Input K/N changes during RUN are ignored until the next frame.
- `rst` mid-frame aborts the frame immediately. The next valid pixel starts a new frame.

## Timing
- Window latency: `fu_window_valid_out` and the data are registered, one cycle after the clock edge that accepts the completing pixel.
- `frame_done_out` asserts on the same cycle as the window for the last pixel, if that pixel emits one.
- Throughput: one pixel per cycle; at most one window per cycle.
- Back-to-back frames: a pixel on the cycle after `frame_done_out` starts the next frame with no bubble.
- Windows emitted per valid frame: (N-K+1)².

## Test plan
- **K=3, N=4, pixels 100..115 continuous:**
  - 4 windows, each one cycle after pixels 110, 111, 114, 115.
  - First window = 100,101,102,104,105,106,108,109,110; fourth window = 105,106,107,109,110,111,113,114,115.
  - Entries 9..24 = 0; `frame_done_out` on the cycle of the fourth window.
- **Same frame with `fu_pixel_valid_in` toggled 1-0-1-0:** identical window contents; each window strobe one cycle after its completing pixel.
- **K=1, N=4:** 16 windows, entry 0 = pixel, others 0. **K=5, N=4:** 0 windows, `frame_done_out` after pixel 16, `cfg_err_out` = 0.
- **K=6 (>MAX) or N=100 (>MAX_IMG_SIZE):** `cfg_err_out` = 1 from the cycle after the first pixel and stays 1; no windows are emitted.
- **`rst` pulsed after 7 pixels of a K=3, N=4 frame, then a fresh 16-pixel frame:**
  - All outputs read 0 during reset.
  - Fresh frame produces the same 4 windows as the first scenario.
- **Back-to-back frames, K=3/N=4 then K=2/N=3 (pixels 0..8), no gap:**
  - Second frame emits 4 windows: {0,1,3,4}, {1,2,4,5}, {3,4,6,7}, {4,5,7,8}.
